// File: rtl/music_pkg.sv
// Shared constants, FSM state type and note decoding for the music sequencer.
package music_pkg;

   localparam logic [7:0] NOTE_REST = 8'h00;
   localparam logic [7:0] NOTE_END  = 8'hFF;

   localparam int BASE_HP_W = 19;

   // Half periods in 50 MHz cycles for octave 0 (C2..B2), round(50e6 / (2*f)).
   localparam logic [BASE_HP_W-1:0] BASE_HP [0:11] = '{
      19'd382226, 19'd360773, 19'd340524, 19'd321412,
      19'd303373, 19'd286346, 19'd270274, 19'd255105,
      19'd240787, 19'd227273, 19'd214517, 19'd202477
   };

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY} state_t;

   typedef struct packed {
      logic                 rest;
      logic [BASE_HP_W-1:0] hp;
   } note_t;

   // Byte -> {rest, half period}. The end marker decodes as a rest; only
   // channel 0 gives it meaning, and that is handled by the FSM.
   function automatic note_t note_decode(input logic [7:0] b);
      note_t n;
      n.rest = 1'b1;
      n.hp   = '0;
      if (b != NOTE_REST && b != NOTE_END && b[3:0] < 4'd12) begin
         n.rest = 1'b0;
         n.hp   = BASE_HP[b[3:0]] >> b[6:4];
      end
      return n;
   endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave voice: reloadable half-period counter plus output phase.
module tone_channel #(
   parameter int HP_W = 19
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic            rest,
   input  logic [HP_W-1:0] half_period,
   output logic            wave
);

   logic            rest_q, rest_d;
   logic [HP_W-1:0] hp_q, hp_d;
   logic [HP_W-1:0] cnt_q, cnt_d;
   logic            wave_q, wave_d;

   // Load re-phases to 0; counter runs hp cycles per half wave, idle on rest.
   always_comb begin
      rest_d = rest_q;
      hp_d   = hp_q;
      cnt_d  = cnt_q;
      wave_d = wave_q;
      if (load) begin
         rest_d = rest;
         hp_d   = half_period;
         cnt_d  = rest ? '0 : half_period - HP_W'(1);
         wave_d = 1'b0;
      end else if (!rest_q) begin
         if (cnt_q == '0) begin
            cnt_d  = hp_q - HP_W'(1);
            wave_d = ~wave_q;
         end else begin
            cnt_d = cnt_q - HP_W'(1);
         end
      end
   end

   // Channel state registers; reset leaves the voice at rest.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rest_q <= 1'b1;
         hp_q   <= '0;
         cnt_q  <= '0;
         wave_q <= 1'b0;
      end else begin
         rest_q <= rest_d;
         hp_q   <= hp_d;
         cnt_q  <= cnt_d;
         wave_q <= wave_d;
      end
   end

   assign wave = wave_q;

endmodule

// File: rtl/music_sequencer.sv
// Multi-channel tune player: walks a synchronous note ROM, one note byte per
// channel per step, with start/stop, loop, end markers and runtime tempo.
module music_sequencer #(
   parameter int NCH     = 2,
   parameter int ADDR_W  = 8,
   parameter int TEMPO_W = 24,
   parameter int HP_W    = 19
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enabled,
   input  logic               start,
   input  logic               stop,
   input  logic               loop,
   input  logic [TEMPO_W-1:0] tempo_div,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [NCH*8-1:0]   rom_data,
   output logic [NCH-1:0]     speaker,
   output logic               playing,
   output logic               done
);
   import music_pkg::*;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [TEMPO_W-1:0] tempo_q, tempo_d;
   logic               done_q, done_d;
   logic               eos;
   logic [NCH-1:0]     ch_load, ch_rest, dec_rest, wave;
   logic [NCH-1:0][HP_W-1:0] dec_hp;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      note_t dec;
      assign dec         = note_decode(rom_data[8*i +: 8]);
      assign dec_rest[i] = dec.rest;
      assign dec_hp[i]   = HP_W'(dec.hp);

      tone_channel #(.HP_W(HP_W)) u_ch (
         .clock       (clock),
         .reset       (reset),
         .load        (ch_load[i]),
         .rest        (ch_rest[i]),
         .half_period (dec_hp[i]),
         .wave        (wave[i])
      );
   end

   // Sequencer FSM: stop beats start beats normal stepping; end of song either
   // wraps (notes keep sounding) or silences every channel and pulses done.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      tempo_d = tempo_q;
      done_d  = 1'b0;
      ch_load = '0;
      ch_rest = '0;
      eos     = 1'b0;
      if (stop) begin
         state_d = S_IDLE;
         addr_d  = '0;
         ch_load = '1;
         ch_rest = '1;
      end else if (start) begin
         state_d = S_FETCH;
         addr_d  = '0;
      end else begin
         case (state_q)
            S_IDLE:  ;
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
               if (rom_data[7:0] == NOTE_END) begin
                  eos = 1'b1;
               end else begin
                  ch_load = '1;
                  ch_rest = dec_rest;
                  tempo_d = tempo_div;
                  state_d = S_PLAY;
               end
            end
            S_PLAY: begin
               if (tempo_q == '0) begin
                  if (&addr_q) begin
                     eos = 1'b1;
                  end else begin
                     addr_d  = addr_q + ADDR_W'(1);
                     state_d = S_FETCH;
                  end
               end else begin
                  tempo_d = tempo_q - TEMPO_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
         if (eos) begin
            addr_d = '0;
            if (loop) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               ch_load = '1;
               ch_rest = '1;
            end
         end
      end
   end

   // FSM, address, tempo and done registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         tempo_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         tempo_q <= tempo_d;
         done_q  <= done_d;
      end
   end

   assign rom_addr = addr_q;
   assign done     = done_q;
   assign playing  = (state_q != S_IDLE);
   assign speaker  = wave & {NCH{enabled}};

endmodule
